ma_pma_region_table: RTL and testbench
======================================

// Module: ma_pma_region_table
// PURPOSE
//  Runtime-programmable physical-memory-attribute table for the MA CVA6 SoC.
//  Generalises the static execute/cached/non-idempotent region rules into NR_REGIONS
//  software-writable entries with per-entry lock.
//  Answers pipelined address lookups (1-cycle latency, valid/ready) for fetch/LSU/accelerator ports.
// PARAMETERS
//  NR_REGIONS    4                  number of table entries (1..16)
//  ADDR_WIDTH    64                 lookup address, base and length width
//  RST_BASE      '{default:'0}      per-entry reset base address, [NR_REGIONS][ADDR_WIDTH]
//  RST_LEN       '{default:'0}      per-entry reset length in bytes; 0 = entry never matches
//  RST_ATTR      '{default:'0}      per-entry reset attr {L,N,C,X}, [NR_REGIONS][4]
//  DEFAULT_ATTR  3'b000             {N,C,X} reported on a miss
// PORTS
//  clk_i          in   1                   clock
//  rst_i          in   1                   synchronous active-high reset
//  cfg_req_i      in   1                   config access request (one per ack)
//  cfg_we_i       in   1                   1 = write, 0 = read
//  cfg_idx_i      in   $clog2(NR_REGIONS)  entry index (use 1 bit min)
//  cfg_field_i    in   2                   0=base 1=len 2=attr 3=reserved
//  cfg_wdata_i    in   ADDR_WIDTH          write data (attr uses [3:0] = {L,N,C,X})
//  cfg_ack_o      out  1                   access complete
//  cfg_rdata_o    out  ADDR_WIDTH          read data, valid with ack
//  cfg_err_o      out  1                   error, valid with ack
//  lkp_valid_i    in   1                   lookup request valid
//  lkp_ready_o    out  1                   lookup request accepted when valid&ready
//  lkp_addr_i     in   ADDR_WIDTH          address to classify
//  lkp_valid_o    out  1                   result valid
//  lkp_ready_i    in   1                   result consumed when valid&ready
//  lkp_hit_o      out  1                   an entry matched
//  lkp_idx_o      out  $clog2(NR_REGIONS)  matching entry (0 on miss)
//  lkp_attr_o     out  3                   {N,C,X} of matching entry or DEFAULT_ATTR
// BEHAVIOUR
//  Reset (rst_i sampled high at posedge): entries <= RST_BASE/RST_LEN/RST_ATTR;
//   cfg_ack_o=0, cfg_err_o=0, cfg_rdata_o=0, lkp_valid_o=0, lkp_hit_o=0, lkp_idx_o=0,
//   lkp_attr_o=0. Reset mid-lookup drops the in-flight result; mid-config drops the ack.
//  Config: cfg_req_i high at edge k -> cfg_ack_o high for exactly one cycle at k+1.
//   Requester holds signals until ack; next request no earlier than the cycle after ack.
//   Write takes effect at edge k; read returns value sampled at k (attr zero-extended).
//   err=1, no state change: idx >= NR_REGIONS, field==3, or write to entry with L=1.
//   Lock is sticky: cleared only by reset; a write setting L also writes N,C,X.
//  Match: entry i hits iff LEN!=0 and BASE <= addr and {1'b0,addr} < {1'b0,BASE}+LEN,
//   sum computed in ADDR_WIDTH+1 bits (no wrap; region ending at 2^ADDR_WIDTH allowed).
//   Multiple hits: lowest index wins. Miss: hit=0, idx=0, attr=DEFAULT_ATTR.
//  Lookup pipeline: single output register.
//   lkp_ready_o = !lkp_valid_o || lkp_ready_i (combinational pass-through of ready).
//   Accept at edge k -> result registered, lkp_valid_o=1 from k+1; held stable until consumed.
//   Back-to-back: accept every cycle while lkp_ready_i=1 -> throughput 1/cycle.
//   Result uses table contents before any config write in the same cycle (old value).
//   Config writes never alter an already-registered result.
//  No combinational path from lkp_addr_i to any output.
// TESTING
//  Reset RST_BASE[0]=0x8000_0000 LEN=0x10_0000 ATTR=4'b0011; lookup 0x800F_FFFF -> hit=1
//   idx=0 attr=3'b011 one cycle later; lookup 0x8010_0000 -> hit=0 attr=DEFAULT_ATTR.
//  Write entry1 base=0x1000_0000 len=0x1000 attr=4'b0100, overlapping entry2 same range attr=4'b0001;
//   lookup 0x1000_0800 -> idx=1 attr=3'b100 (lowest index wins).
//  Write entry0 attr=4'b1001 then base=0 -> second ack err=1, readback base=0x8000_0000;
//   idx=NR_REGIONS -> err=1; field=3 -> err=1.
//  Stream 8 lookups with lkp_ready_i low 3 cycles mid-burst -> lkp_valid_o/outputs held
//   stable while stalled, all 8 results in order, none lost/duplicated, 1/cycle otherwise.
//  Same cycle: write entry3 len=0x100 base 0 (was len 0) and lookup 0x10 -> miss;
//   next lookup 0x10 -> hit idx=3.
//  Entry base=2^64-0x100 len=0x100: lookup 2^64-1 -> hit; assert rst_i with result pending ->
//   lkp_valid_o=0 next cycle and table back to RST_* values.

Source files
------------

// File: rtl/ma_pma_region_table.sv
// ma_pma_region_table
// Runtime-programmable physical-memory-attribute table. NR_REGIONS entries of
// {BASE, LEN, ATTR={L,N,C,X}} are written and read through a simple req/ack
// config port. Lookups are classified against the table and returned through
// a single registered output stage with valid/ready handshaking.
module ma_pma_region_table #(
  parameter int unsigned NR_REGIONS = 4,
  parameter int unsigned ADDR_WIDTH = 64,
  parameter logic [NR_REGIONS-1:0][ADDR_WIDTH-1:0] RST_BASE = '0,
  parameter logic [NR_REGIONS-1:0][ADDR_WIDTH-1:0] RST_LEN  = '0,
  parameter logic [NR_REGIONS-1:0][3:0]            RST_ATTR = '0,
  parameter logic [2:0] DEFAULT_ATTR = 3'b000,
  localparam int unsigned IDX_W = (NR_REGIONS > 1) ? $clog2(NR_REGIONS) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  // configuration port
  input  logic                  cfg_req_i,
  input  logic                  cfg_we_i,
  input  logic [IDX_W-1:0]      cfg_idx_i,
  input  logic [1:0]            cfg_field_i,
  input  logic [ADDR_WIDTH-1:0] cfg_wdata_i,
  output logic                  cfg_ack_o,
  output logic [ADDR_WIDTH-1:0] cfg_rdata_o,
  output logic                  cfg_err_o,
  // lookup request
  input  logic                  lkp_valid_i,
  output logic                  lkp_ready_o,
  input  logic [ADDR_WIDTH-1:0] lkp_addr_i,
  // lookup result
  output logic                  lkp_valid_o,
  input  logic                  lkp_ready_i,
  output logic                  lkp_hit_o,
  output logic [IDX_W-1:0]      lkp_idx_o,
  output logic [2:0]            lkp_attr_o
);

  localparam logic [1:0] FLD_BASE = 2'd0;
  localparam logic [1:0] FLD_LEN  = 2'd1;
  localparam logic [1:0] FLD_ATTR = 2'd2;
  localparam logic [1:0] FLD_RSVD = 2'd3;

  // Table storage
  logic [ADDR_WIDTH-1:0] r_base [NR_REGIONS];
  logic [ADDR_WIDTH-1:0] r_len  [NR_REGIONS];
  logic [3:0]            r_attr [NR_REGIONS];

  // Config response registers
  logic                  r_cfg_ack;
  logic                  r_cfg_err;
  logic [ADDR_WIDTH-1:0] r_cfg_rdata;

  // Lookup output stage
  logic                  r_vld_p1;
  logic                  r_hit_p1;
  logic [IDX_W-1:0]      r_idx_p1;
  logic [2:0]            r_attr_p1;

  // Config decode
  logic                  w_cfg_fire;
  logic                  w_idx_ok;
  logic                  w_cfg_err;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_sel_base;
  logic [ADDR_WIDTH-1:0] w_sel_len;
  logic [3:0]            w_sel_attr;
  logic [ADDR_WIDTH-1:0] w_rd_val;

  // Lookup match
  logic [NR_REGIONS-1:0] w_hit_vec;
  logic                  w_any_hit;
  logic [IDX_W-1:0]      w_hit_idx;
  logic [2:0]            w_hit_attr;
  logic                  w_lkp_acc;

  // The index port can encode values past the last entry when NR_REGIONS is
  // not a power of two; those accesses are rejected rather than aliased.
  assign w_idx_ok = (32'(cfg_idx_i) < NR_REGIONS);

  // A request is ignored during its own ack cycle so a requester that drops
  // req right after seeing ack is never serviced twice.
  assign w_cfg_fire = cfg_req_i && !r_cfg_ack;

  // Select the entry addressed by the config port (zero if out of range)
  always_comb begin
    w_sel_base = '0;
    w_sel_len  = '0;
    w_sel_attr = '0;
    for (int i = 0; i < NR_REGIONS; i++) begin
      if (cfg_idx_i == IDX_W'(i)) begin
        w_sel_base = r_base[i];
        w_sel_len  = r_len[i];
        w_sel_attr = r_attr[i];
      end
    end
  end

  // Locked entries reject every write; the lock bit itself can only be
  // cleared by reset.
  assign w_cfg_err = !w_idx_ok || (cfg_field_i == FLD_RSVD) ||
                     (cfg_we_i && w_sel_attr[3]);
  assign w_wr_en   = w_cfg_fire && cfg_we_i && !w_cfg_err;

  // Read-data multiplexer; attr is zero-extended to the data width
  always_comb begin
    w_rd_val = '0;
    case (cfg_field_i)
      FLD_BASE: w_rd_val = w_sel_base;
      FLD_LEN:  w_rd_val = w_sel_len;
      FLD_ATTR: w_rd_val = {{(ADDR_WIDTH-4){1'b0}}, w_sel_attr};
      default:  w_rd_val = '0;
    endcase
  end

  // Table update: reset restores the RST_* image, accepted writes update one field
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NR_REGIONS; i++) begin
      if (rst_i) begin
        r_base[i] <= RST_BASE[i];
        r_len[i]  <= RST_LEN[i];
        r_attr[i] <= RST_ATTR[i];
      end else if (w_wr_en && (cfg_idx_i == IDX_W'(i))) begin
        case (cfg_field_i)
          FLD_BASE: r_base[i] <= cfg_wdata_i;
          FLD_LEN:  r_len[i]  <= cfg_wdata_i;
          FLD_ATTR: r_attr[i] <= cfg_wdata_i[3:0];
          default:  ;
        endcase
      end
    end
  end

  // Config response: one-cycle ack with error flag and read data
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cfg_ack   <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_cfg_rdata <= '0;
    end else begin
      r_cfg_ack <= w_cfg_fire;
      r_cfg_err <= w_cfg_fire && w_cfg_err;
      if (w_cfg_fire) begin
        r_cfg_rdata <= (!cfg_we_i && !w_cfg_err) ? w_rd_val : '0;
      end
    end
  end

  // Per-entry range compare; the end address carries one extra bit so a
  // region reaching the top of the address space does not wrap to zero.
  for (genvar g = 0; g < NR_REGIONS; g++) begin : g_match
    logic [ADDR_WIDTH:0] w_end;
    assign w_end        = {1'b0, r_base[g]} + {1'b0, r_len[g]};
    assign w_hit_vec[g] = (r_len[g] != '0) &&
                          (lkp_addr_i >= r_base[g]) &&
                          ({1'b0, lkp_addr_i} < w_end);
  end

  // Priority select: the lowest matching index wins
  always_comb begin
    w_any_hit  = 1'b0;
    w_hit_idx  = '0;
    w_hit_attr = DEFAULT_ATTR;
    for (int i = int'(NR_REGIONS) - 1; i >= 0; i--) begin
      if (w_hit_vec[i]) begin
        w_any_hit  = 1'b1;
        w_hit_idx  = IDX_W'(i);
        w_hit_attr = r_attr[i][2:0];
      end
    end
  end

  assign lkp_ready_o = !r_vld_p1 || lkp_ready_i;
  assign w_lkp_acc   = lkp_valid_i && lkp_ready_o;

  // Lookup output stage: capture on accept, hold until consumed
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_vld_p1  <= 1'b0;
      r_hit_p1  <= 1'b0;
      r_idx_p1  <= '0;
      r_attr_p1 <= '0;
    end else if (w_lkp_acc) begin
      r_vld_p1  <= 1'b1;
      r_hit_p1  <= w_any_hit;
      r_idx_p1  <= w_hit_idx;
      r_attr_p1 <= w_hit_attr;
    end else if (lkp_ready_i) begin
      r_vld_p1  <= 1'b0;
    end
  end

  assign cfg_ack_o   = r_cfg_ack;
  assign cfg_err_o   = r_cfg_err;
  assign cfg_rdata_o = r_cfg_rdata;
  assign lkp_valid_o = r_vld_p1;
  assign lkp_hit_o   = r_hit_p1;
  assign lkp_idx_o   = r_idx_p1;
  assign lkp_attr_o  = r_attr_p1;

endmodule

// File: tb/tb_ma_pma_region_table.sv
// Testbench for ma_pma_region_table: directed config/lookup vectors with a
// queue-based scoreboard checked by an independent monitor process.
module tb_ma_pma_region_table;

  localparam int unsigned NR = 5;
  localparam int unsigned AW = 64;
  localparam int unsigned IW = 3;
  localparam logic [NR-1:0][AW-1:0] P_BASE = {64'h0, 64'h0, 64'h0, 64'h0, 64'h8000_0000};
  localparam logic [NR-1:0][AW-1:0] P_LEN  = {64'h0, 64'h0, 64'h0, 64'h0, 64'h0010_0000};
  localparam logic [NR-1:0][3:0]    P_ATTR = {4'h0, 4'h0, 4'h0, 4'h0, 4'b0011};
  localparam logic [2:0]            P_DEF  = 3'b010;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_req = 1'b0;
  logic          cfg_we = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [1:0]    cfg_field = '0;
  logic [AW-1:0] cfg_wdata = '0;
  logic          cfg_ack_o;
  logic [AW-1:0] cfg_rdata_o;
  logic          cfg_err_o;
  logic          lkp_valid = 1'b0;
  logic          lkp_ready_o;
  logic [AW-1:0] lkp_addr = '0;
  logic          lkp_valid_o;
  logic          lkp_ready = 1'b1;
  logic          lkp_hit_o;
  logic [IW-1:0] lkp_idx_o;
  logic [2:0]    lkp_attr_o;

  ma_pma_region_table #(
    .NR_REGIONS  (NR),
    .ADDR_WIDTH  (AW),
    .RST_BASE    (P_BASE),
    .RST_LEN     (P_LEN),
    .RST_ATTR    (P_ATTR),
    .DEFAULT_ATTR(P_DEF)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cfg_req_i  (cfg_req),
    .cfg_we_i   (cfg_we),
    .cfg_idx_i  (cfg_idx),
    .cfg_field_i(cfg_field),
    .cfg_wdata_i(cfg_wdata),
    .cfg_ack_o  (cfg_ack_o),
    .cfg_rdata_o(cfg_rdata_o),
    .cfg_err_o  (cfg_err_o),
    .lkp_valid_i(lkp_valid),
    .lkp_ready_o(lkp_ready_o),
    .lkp_addr_i (lkp_addr),
    .lkp_valid_o(lkp_valid_o),
    .lkp_ready_i(lkp_ready),
    .lkp_hit_o  (lkp_hit_o),
    .lkp_idx_o  (lkp_idx_o),
    .lkp_attr_o (lkp_attr_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          err;
    logic          chk_rd;
    logic [AW-1:0] rd;
  } cexp_t;

  typedef struct packed {
    logic          hit;
    logic [IW-1:0] idx;
    logic [2:0]    attr;
    logic [AW-1:0] addr;
  } lexp_t;

  cexp_t cq[$];
  string cq_nm[$];
  lexp_t lq[$];

  int checks   = 0;
  int failures = 0;
  int lk_edges = 0;

  task automatic chk(input string nm, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=response", nm);
  endtask

  // Issue one config access, hold it until ack (bounded)
  task automatic do_cfg(input logic we, input logic [IW-1:0] idx, input logic [1:0] fld,
                        input logic [AW-1:0] wd, input logic exp_err,
                        input logic chk_rd, input logic [AW-1:0] exp_rd, input string nm);
    int n;
    cq.push_back('{err: exp_err, chk_rd: chk_rd, rd: exp_rd});
    cq_nm.push_back(nm);
    cfg_req = 1'b1; cfg_we = we; cfg_idx = idx; cfg_field = fld; cfg_wdata = wd;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!cfg_ack_o && n < 10);
    cfg_req = 1'b0;
    if (!cfg_ack_o) fail_now({nm, "_ack"});
  endtask

  // Offer one lookup and wait until it is accepted (bounded)
  task automatic do_lkp(input logic [AW-1:0] a, input logic hit, input logic [IW-1:0] idx,
                        input logic [2:0] attr);
    int n;
    logic acc;
    lq.push_back('{hit: hit, idx: idx, attr: attr, addr: a});
    lkp_valid = 1'b1; lkp_addr = a;
    n = 0; acc = 1'b0;
    do begin
      @(negedge clk); acc = lkp_ready_o;
      @(posedge clk); #1; n++;
    end while (!acc && n < 50);
    lkp_valid = 1'b0;
    lk_edges += n;
    if (!acc) fail_now("lkp_accept");
  endtask

  // Monitor: compares DUT responses against the scoreboard queues
  logic          stalled = 1'b0;
  logic [6:0]    held;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", AW'(lkp_valid_o), AW'(1'b1));
        chk("stall_data", AW'({lkp_hit_o, lkp_idx_o, lkp_attr_o}), AW'(held));
      end
      if (lkp_valid_o && lkp_ready) begin
        if (lq.size() == 0) begin
          chk("lkp_unexpected", AW'(lkp_valid_o), AW'(1'b0));
        end else begin
          lexp_t e;
          e = lq.pop_front();
          chk($sformatf("lkp_hit@%h", e.addr), AW'(lkp_hit_o), AW'(e.hit));
          chk($sformatf("lkp_idx@%h", e.addr), AW'(lkp_idx_o), AW'(e.idx));
          chk($sformatf("lkp_attr@%h", e.addr), AW'(lkp_attr_o), AW'(e.attr));
        end
      end
      stalled = lkp_valid_o && !lkp_ready;
      held    = {lkp_hit_o, lkp_idx_o, lkp_attr_o};
      if (cfg_ack_o) begin
        if (cq.size() == 0) begin
          chk("cfg_unexpected_ack", AW'(cfg_ack_o), AW'(1'b0));
        end else begin
          cexp_t c;
          string nm;
          c  = cq.pop_front();
          nm = cq_nm.pop_front();
          chk({nm, "_err"}, AW'(cfg_err_o), AW'(c.err));
          if (c.chk_rd) chk({nm, "_rdata"}, cfg_rdata_o, c.rd);
        end
      end
    end
  end

  logic [AW-1:0] sa [8];
  logic          sh [8];
  logic [IW-1:0] si [8];
  logic [2:0]    sx [8];

  initial begin
    // Reset state
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_cfg_ack",   AW'(cfg_ack_o),   '0);
    chk("rst_cfg_err",   AW'(cfg_err_o),   '0);
    chk("rst_cfg_rdata", cfg_rdata_o,      '0);
    chk("rst_lkp_valid", AW'(lkp_valid_o), '0);
    chk("rst_lkp_hit",   AW'(lkp_hit_o),   '0);
    chk("rst_lkp_idx",   AW'(lkp_idx_o),   '0);
    chk("rst_lkp_attr",  AW'(lkp_attr_o),  '0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_lkp_ready", AW'(lkp_ready_o), AW'(1'b1));
    @(posedge clk); #1;

    // Reset-programmed entry 0 and its upper boundary
    do_lkp(64'h800F_FFFF, 1'b1, 3'd0, 3'b011);
    do_lkp(64'h8010_0000, 1'b0, 3'd0, P_DEF);
    do_lkp(64'h7FFF_FFFF, 1'b0, 3'd0, P_DEF);

    // Overlapping entries 1 and 2: lowest index wins
    do_cfg(1'b1, 3'd1, 2'd0, 64'h1000_0000, 1'b0, 1'b0, '0, "wr_e1_base");
    do_cfg(1'b1, 3'd1, 2'd1, 64'h1000,      1'b0, 1'b0, '0, "wr_e1_len");
    do_cfg(1'b1, 3'd1, 2'd2, 64'b0100,      1'b0, 1'b0, '0, "wr_e1_attr");
    do_cfg(1'b1, 3'd2, 2'd0, 64'h1000_0000, 1'b0, 1'b0, '0, "wr_e2_base");
    do_cfg(1'b1, 3'd2, 2'd1, 64'h1000,      1'b0, 1'b0, '0, "wr_e2_len");
    do_cfg(1'b1, 3'd2, 2'd2, 64'b0001,      1'b0, 1'b0, '0, "wr_e2_attr");
    do_lkp(64'h1000_0800, 1'b1, 3'd1, 3'b100);
    do_lkp(64'h1000_1000, 1'b0, 3'd0, P_DEF);
    do_cfg(1'b0, 3'd1, 2'd1, '0, 1'b0, 1'b1, 64'h1000, "rd_e1_len");

    // Lock and error cases
    do_cfg(1'b1, 3'd0, 2'd2, 64'b1001, 1'b0, 1'b0, '0, "wr_e0_lock");
    do_cfg(1'b1, 3'd0, 2'd0, 64'h0,    1'b1, 1'b0, '0, "wr_e0_base_locked");
    do_cfg(1'b0, 3'd0, 2'd0, '0, 1'b0, 1'b1, 64'h8000_0000, "rd_e0_base");
    do_cfg(1'b0, 3'd0, 2'd2, '0, 1'b0, 1'b1, 64'h9, "rd_e0_attr");
    do_cfg(1'b1, 3'd0, 2'd1, 64'h0, 1'b1, 1'b0, '0, "wr_e0_len_locked");
    do_cfg(1'b0, 3'd5, 2'd0, '0, 1'b1, 1'b0, '0, "rd_idx_oob");
    do_cfg(1'b0, 3'd1, 2'd3, '0, 1'b1, 1'b0, '0, "rd_field3");
    do_cfg(1'b1, 3'd7, 2'd0, 64'h1, 1'b1, 1'b0, '0, "wr_idx_oob");
    do_lkp(64'h8000_0000, 1'b1, 3'd0, 3'b001);

    // Streamed lookups with a 3-cycle result stall mid-burst
    sa[0] = 64'h1000_0000; sh[0] = 1; si[0] = 1; sx[0] = 3'b100;
    sa[1] = 64'h8000_0010; sh[1] = 1; si[1] = 0; sx[1] = 3'b001;
    sa[2] = 64'h1000_0FFF; sh[2] = 1; si[2] = 1; sx[2] = 3'b100;
    sa[3] = 64'h0FFF_FFFF; sh[3] = 0; si[3] = 0; sx[3] = P_DEF;
    sa[4] = 64'h8000_0000; sh[4] = 1; si[4] = 0; sx[4] = 3'b001;
    sa[5] = 64'h1000_1000; sh[5] = 0; si[5] = 0; sx[5] = P_DEF;
    sa[6] = 64'h800F_FFFF; sh[6] = 1; si[6] = 0; sx[6] = 3'b001;
    sa[7] = 64'h1000_0004; sh[7] = 1; si[7] = 1; sx[7] = 3'b100;
    lk_edges = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) do_lkp(sa[i], sh[i], si[i], sx[i]);
      end
      begin
        repeat (3) @(posedge clk);
        #1 lkp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 lkp_ready = 1'b1;
      end
    join
    chk("stream_edges", AW'(lk_edges), AW'(11));

    // Config write and lookup in the same cycle: lookup sees the old table
    do_cfg(1'b1, 3'd3, 2'd0, 64'h0,    1'b0, 1'b0, '0, "wr_e3_base");
    do_cfg(1'b1, 3'd3, 2'd2, 64'b0110, 1'b0, 1'b0, '0, "wr_e3_attr");
    fork
      do_cfg(1'b1, 3'd3, 2'd1, 64'h100, 1'b0, 1'b0, '0, "wr_e3_len");
      do_lkp(64'h10, 1'b0, 3'd0, P_DEF);
    join
    do_lkp(64'h10,  1'b1, 3'd3, 3'b110);
    do_lkp(64'h100, 1'b0, 3'd0, P_DEF);

    // Region ending exactly at the top of the address space
    do_cfg(1'b1, 3'd4, 2'd0, 64'hFFFF_FFFF_FFFF_FF00, 1'b0, 1'b0, '0, "wr_e4_base");
    do_cfg(1'b1, 3'd4, 2'd1, 64'h100,  1'b0, 1'b0, '0, "wr_e4_len");
    do_cfg(1'b1, 3'd4, 2'd2, 64'b0101, 1'b0, 1'b0, '0, "wr_e4_attr");
    do_lkp(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd4, 3'b101);
    do_lkp(64'hFFFF_FFFF_FFFF_FEFF, 1'b0, 3'd0, P_DEF);

    // Reset with a result pending: result dropped, table restored
    @(posedge clk); #1 lkp_ready = 1'b0;
    do_lkp(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 3'd4, 3'b101);
    chk("pend_valid", AW'(lkp_valid_o), AW'(1'b1));
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_drop_valid", AW'(lkp_valid_o), '0);
    chk("rst_drop_hit",   AW'(lkp_hit_o),   '0);
    chk("rst_drop_attr",  AW'(lkp_attr_o),  '0);
    lq.delete();
    lkp_ready = 1'b1;
    @(posedge clk); #1;
    do_cfg(1'b0, 3'd0, 2'd2, '0, 1'b0, 1'b1, 64'h3,          "rst_rd_e0_attr");
    do_cfg(1'b0, 3'd0, 2'd0, '0, 1'b0, 1'b1, 64'h8000_0000, "rst_rd_e0_base");
    do_cfg(1'b0, 3'd1, 2'd1, '0, 1'b0, 1'b1, 64'h0,          "rst_rd_e1_len");
    do_cfg(1'b0, 3'd4, 2'd0, '0, 1'b0, 1'b1, 64'h0,          "rst_rd_e4_base");
    do_cfg(1'b0, 3'd3, 2'd1, '0, 1'b0, 1'b1, 64'h0,          "rst_rd_e3_len");
    do_cfg(1'b1, 3'd0, 2'd0, 64'h8000_0000, 1'b0, 1'b0, '0,  "rst_wr_e0_unlocked");
    do_lkp(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 3'd0, P_DEF);
    do_lkp(64'h800F_FFFF, 1'b1, 3'd0, 3'b011);
    do_lkp(64'h10, 1'b0, 3'd0, P_DEF);

    // Drain and confirm nothing is left outstanding
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("lkp_queue_empty", AW'(lq.size()), '0);
    chk("cfg_queue_empty", AW'(cq.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard against a hung run
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
